// File: rtl/cell_bank_scheduler_if.sv
// Requester, status and RAM-port bundle for cell_bank_scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding top level.
interface cell_bank_scheduler_if #(
   parameter int ADDR_W = 24,
   parameter int GEN_W  = 16
);
   logic              load_req;
   logic              load_gnt;
   logic              load_wen;
   logic [ADDR_W-1:0] load_addr;
   logic              load_data;
   logic              evo_en;
   logic              evo_rreq;
   logic [ADDR_W-1:0] evo_raddr;
   logic              evo_rgnt;
   logic              evo_rvalid;
   logic              evo_rdata;
   logic              evo_wen;
   logic [ADDR_W-1:0] evo_waddr;
   logic              evo_wdata;
   logic              gen_done;
   logic              vga_ren;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_rvalid;
   logic              vga_rdata;
   logic              edit_req;
   logic [ADDR_W-1:0] edit_addr;
   logic              edit_busy;
   logic              edit_done;
   logic              cur_bank;
   logic [GEN_W-1:0]  gen_count;
   logic [ADDR_W-1:0] ram0_addr;
   logic              ram0_wren;
   logic              ram0_rden;
   logic              ram0_data;
   logic              ram0_q;
   logic [ADDR_W-1:0] ram1_addr;
   logic              ram1_wren;
   logic              ram1_rden;
   logic              ram1_data;
   logic              ram1_q;

   modport slave (
      input  load_req, load_wen, load_addr, load_data,
      input  evo_en, evo_rreq, evo_raddr, evo_wen, evo_waddr, evo_wdata, gen_done,
      input  vga_ren, vga_addr, edit_req, edit_addr, ram0_q, ram1_q,
      output load_gnt, evo_rgnt, evo_rvalid, evo_rdata, vga_rvalid, vga_rdata,
      output edit_busy, edit_done, cur_bank, gen_count,
      output ram0_addr, ram0_wren, ram0_rden, ram0_data,
      output ram1_addr, ram1_wren, ram1_rden, ram1_data
   );

   modport master (
      output load_req, load_wen, load_addr, load_data,
      output evo_en, evo_rreq, evo_raddr, evo_wen, evo_waddr, evo_wdata, gen_done,
      output vga_ren, vga_addr, edit_req, edit_addr, ram0_q, ram1_q,
      input  load_gnt, evo_rgnt, evo_rvalid, evo_rdata, vga_rvalid, vga_rdata,
      input  edit_busy, edit_done, cur_bank, gen_count,
      input  ram0_addr, ram0_wren, ram0_rden, ram0_data,
      input  ram1_addr, ram1_wren, ram1_rden, ram1_data
   );
endinterface

// File: rtl/cell_bank_scheduler.sv
// Shares the current/next generation cell banks between loader, evolution engine,
// VGA scanner and the read-modify-write cell editor; flips banks per generation.
module cell_bank_scheduler #(
   parameter int ADDR_W = 24,
   parameter int GEN_W  = 16
) (
   input logic                  clk_vga,
   input logic                  reset_n,
   cell_bank_scheduler_if.slave bus
);
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_E_RD = 3'd3;
   localparam logic [2:0] ST_E_WT = 3'd4;
   localparam logic [2:0] ST_E_WR = 3'd5;

   logic [2:0]        state_r, state_nxt_s;
   logic              cur_bank_r;
   logic [GEN_W-1:0]  gen_count_r;
   logic [ADDR_W-1:0] edit_addr_r;
   logic              old_r, load_gnt_r, edit_busy_r, edit_done_r;
   logic              vga_rvalid_r, evo_rvalid_r, rd_bank_r, white_r;
   logic              cur_rden_s, cur_wren_s, cur_data_s;
   logic [ADDR_W-1:0] cur_addr_s;
   logic              nxt_wren_s, nxt_data_s;
   logic [ADDR_W-1:0] nxt_addr_s;
   logic              evo_rgnt_s, edit_wr_s, gen_step_s, q_sel_s;

   assign evo_rgnt_s = (state_r == ST_RUN) & bus.evo_rreq & ~bus.vga_ren;
   assign edit_wr_s  = (state_r == ST_E_WR) & ~bus.vga_ren;
   assign gen_step_s = (state_r == ST_RUN) & bus.gen_done & ~bus.load_req;

   // Next-state decode; load beats edit beats evolution when leaving IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.load_req)      state_nxt_s = ST_LOAD;
            else if (bus.edit_req) state_nxt_s = ST_E_RD;
            else if (bus.evo_en)   state_nxt_s = ST_RUN;
            else                   state_nxt_s = ST_IDLE;
         end
         ST_LOAD: state_nxt_s = bus.load_req ? ST_LOAD : ST_IDLE;
         ST_RUN: begin
            if (bus.load_req)    state_nxt_s = ST_LOAD;
            else if (bus.evo_en) state_nxt_s = ST_RUN;
            else                 state_nxt_s = ST_IDLE;
         end
         ST_E_RD: state_nxt_s = bus.vga_ren ? ST_E_RD : ST_E_WT;
         ST_E_WT: state_nxt_s = ST_E_WR;
         ST_E_WR: state_nxt_s = bus.vga_ren ? ST_E_WR : ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Logical port muxing: "cur" is the displayed bank, "nxt" the bank being built.
   always_comb begin
      cur_rden_s = 1'b0;
      cur_wren_s = 1'b0;
      cur_addr_s = '0;
      cur_data_s = 1'b0;
      nxt_wren_s = 1'b0;
      nxt_addr_s = '0;
      nxt_data_s = 1'b0;
      if (state_r == ST_LOAD) begin
         if (bus.load_wen) begin
            cur_wren_s = 1'b1;
            cur_addr_s = bus.load_addr;
            cur_data_s = bus.load_data;
            nxt_wren_s = 1'b1;
            nxt_addr_s = bus.load_addr;
            nxt_data_s = bus.load_data;
         end else begin
            cur_wren_s = 1'b0;
         end
      end else begin
         if (bus.vga_ren) begin
            cur_rden_s = 1'b1;
            cur_addr_s = bus.vga_addr;
         end else if (evo_rgnt_s) begin
            cur_rden_s = 1'b1;
            cur_addr_s = bus.evo_raddr;
         end else if (state_r == ST_E_RD) begin
            cur_rden_s = 1'b1;
            cur_addr_s = edit_addr_r;
         end else if (edit_wr_s) begin
            cur_wren_s = 1'b1;
            cur_addr_s = edit_addr_r;
            cur_data_s = ~old_r;
         end else begin
            cur_rden_s = 1'b0;
         end
         if (edit_wr_s) begin
            nxt_wren_s = 1'b1;
            nxt_addr_s = edit_addr_r;
            nxt_data_s = ~old_r;
         end else if ((state_r == ST_RUN) && bus.evo_wen) begin
            nxt_wren_s = 1'b1;
            nxt_addr_s = bus.evo_waddr;
            nxt_data_s = bus.evo_wdata;
         end else begin
            nxt_wren_s = 1'b0;
         end
      end
   end

   assign bus.ram0_rden = cur_bank_r ? 1'b0       : cur_rden_s;
   assign bus.ram0_wren = cur_bank_r ? nxt_wren_s : cur_wren_s;
   assign bus.ram0_addr = cur_bank_r ? nxt_addr_s : cur_addr_s;
   assign bus.ram0_data = cur_bank_r ? nxt_data_s : cur_data_s;
   assign bus.ram1_rden = cur_bank_r ? cur_rden_s : 1'b0;
   assign bus.ram1_wren = cur_bank_r ? cur_wren_s : nxt_wren_s;
   assign bus.ram1_addr = cur_bank_r ? cur_addr_s : nxt_addr_s;
   assign bus.ram1_data = cur_bank_r ? cur_data_s : nxt_data_s;

   // Returning read data follows the bank captured at issue, not the live pointer.
   assign q_sel_s = rd_bank_r ? bus.ram1_q : bus.ram0_q;

   // State, bank pointer, generation counter and registered status outputs.
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         cur_bank_r   <= 1'b0;
         gen_count_r  <= '0;
         edit_addr_r  <= '0;
         old_r        <= 1'b0;
         load_gnt_r   <= 1'b0;
         edit_busy_r  <= 1'b0;
         edit_done_r  <= 1'b0;
         vga_rvalid_r <= 1'b0;
         evo_rvalid_r <= 1'b0;
         rd_bank_r    <= 1'b0;
         white_r      <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         load_gnt_r   <= (state_nxt_s == ST_LOAD);
         edit_busy_r  <= (state_nxt_s == ST_E_RD) || (state_nxt_s == ST_E_WT) ||
                         (state_nxt_s == ST_E_WR);
         edit_done_r  <= edit_wr_s;
         vga_rvalid_r <= bus.vga_ren;
         evo_rvalid_r <= evo_rgnt_s;
         rd_bank_r    <= cur_bank_r;
         white_r      <= (state_r == ST_LOAD);
         if (gen_step_s) begin
            cur_bank_r  <= ~cur_bank_r;
            gen_count_r <= gen_count_r + GEN_W'(1'b1);
         end else if ((state_r != ST_LOAD) && (state_nxt_s == ST_LOAD)) begin
            gen_count_r <= '0;
         end else begin
            gen_count_r <= gen_count_r;
         end
         if ((state_r == ST_IDLE) && (state_nxt_s == ST_E_RD)) begin
            edit_addr_r <= bus.edit_addr;
         end else begin
            edit_addr_r <= edit_addr_r;
         end
         if (state_r == ST_E_WT) begin
            old_r <= q_sel_s;
         end else begin
            old_r <= old_r;
         end
      end
   end

   assign bus.load_gnt   = load_gnt_r;
   assign bus.evo_rgnt   = evo_rgnt_s;
   assign bus.evo_rvalid = evo_rvalid_r;
   assign bus.evo_rdata  = q_sel_s;
   assign bus.vga_rvalid = vga_rvalid_r;
   assign bus.vga_rdata  = (white_r | load_gnt_r) ? 1'b1 : q_sel_s;
   assign bus.edit_busy  = edit_busy_r;
   assign bus.edit_done  = edit_done_r;
   assign bus.cur_bank   = cur_bank_r;
   assign bus.gen_count  = gen_count_r;
endmodule

// File: tb/tb_cell_bank_scheduler.sv
// Directed self-checking bench for cell_bank_scheduler with two behavioural 1-bit bank RAMs.
module tb_cell_bank_scheduler;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   n;
   logic mem0 [0:255];
   logic mem1 [0:255];

   cell_bank_scheduler_if #(.ADDR_W(24), .GEN_W(16)) cbi ();

   cell_bank_scheduler #(.ADDR_W(24), .GEN_W(16)) dut (
      .clk_vga (clk),
      .reset_n (rst_n),
      .bus     (cbi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port banks with one-cycle read latency
   always @(posedge clk) begin
      if (cbi.ram0_wren) mem0[cbi.ram0_addr[7:0]] <= cbi.ram0_data;
      if (cbi.ram0_rden) cbi.ram0_q <= mem0[cbi.ram0_addr[7:0]];
      if (cbi.ram1_wren) mem1[cbi.ram1_addr[7:0]] <= cbi.ram1_data;
      if (cbi.ram1_rden) cbi.ram1_q <= mem1[cbi.ram1_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic edit_cycle(input logic [23:0] a, input int hold, output int cnt);
      cbi.edit_req  = 1'b1;
      cbi.edit_addr = a;
      tick();
      cbi.edit_req = 1'b0;
      chk("edit_busy_set", 32'(cbi.edit_busy), 32'd1);
      cbi.vga_ren  = (hold > 0) ? 1'b1 : 1'b0;
      cbi.vga_addr = 24'd5;
      cnt = 0;
      while (!cbi.edit_done && cnt < 20) begin
         tick();
         cnt++;
         if (cnt >= hold) cbi.vga_ren = 1'b0;
      end
      cbi.vga_ren = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 1'b0;
         mem1[i] = 1'b0;
      end
      cbi.ram0_q = 1'b0;   cbi.ram1_q = 1'b0;
      cbi.load_req = 1'b0; cbi.load_wen = 1'b0; cbi.load_addr = 24'd0; cbi.load_data = 1'b0;
      cbi.evo_en = 1'b0;   cbi.evo_rreq = 1'b0; cbi.evo_raddr = 24'd0;
      cbi.evo_wen = 1'b0;  cbi.evo_waddr = 24'd0; cbi.evo_wdata = 1'b0; cbi.gen_done = 1'b0;
      cbi.vga_ren = 1'b0;  cbi.vga_addr = 24'd0;
      cbi.edit_req = 1'b0; cbi.edit_addr = 24'd0;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_load_gnt", 32'(cbi.load_gnt), 32'd0);
      chk("rst_cur_bank", 32'(cbi.cur_bank), 32'd0);
      chk("rst_gen_count", 32'(cbi.gen_count), 32'd0);
      chk("rst_edit_busy", 32'(cbi.edit_busy), 32'd0);
      chk("rst_vga_rvalid", 32'(cbi.vga_rvalid), 32'd0);
      chk("rst_ram0_ctl", 32'({cbi.ram0_wren, cbi.ram0_rden, cbi.ram0_addr}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Loader owns both banks
      cbi.load_req = 1'b1;
      tick();
      chk("load_gnt_up", 32'(cbi.load_gnt), 32'd1);
      cbi.load_wen = 1'b1; cbi.load_addr = 24'd5; cbi.load_data = 1'b1;
      cbi.vga_ren = 1'b1;  cbi.vga_addr = 24'd7;
      #1;
      chk("load_ram0_wr", 32'({cbi.ram0_wren, cbi.ram0_data, cbi.ram0_addr}), {6'd0, 2'b11, 24'd5});
      chk("load_ram1_wr", 32'({cbi.ram1_wren, cbi.ram1_data, cbi.ram1_addr}), {6'd0, 2'b11, 24'd5});
      chk("load_vga_white", 32'(cbi.vga_rdata), 32'd1);
      tick();
      chk("load_vga_rvalid", 32'(cbi.vga_rvalid), 32'd1);
      chk("load_vga_white2", 32'(cbi.vga_rdata), 32'd1);
      cbi.load_req = 1'b0; cbi.load_wen = 1'b0; cbi.vga_ren = 1'b0;
      #1;
      chk("load_gnt_hold", 32'(cbi.load_gnt), 32'd1);
      tick();
      chk("load_gnt_drop", 32'(cbi.load_gnt), 32'd0);

      // VGA reads of the current bank in IDLE
      cbi.vga_ren = 1'b1; cbi.vga_addr = 24'd5;
      #1;
      chk("vga_ram0_rd", 32'({cbi.ram0_rden, cbi.ram1_rden, cbi.ram0_addr}), {6'd0, 2'b10, 24'd5});
      tick();
      chk("vga_rdata_5", 32'({cbi.vga_rvalid, cbi.vga_rdata}), 32'd3);
      cbi.vga_addr = 24'd6;
      tick();
      chk("vga_rdata_6", 32'({cbi.vga_rvalid, cbi.vga_rdata}), 32'd2);
      cbi.vga_ren = 1'b0;

      // RUN: VGA beats evolution on the current bank
      cbi.evo_en = 1'b1;
      tick();
      cbi.evo_rreq = 1'b1; cbi.evo_raddr = 24'd5; cbi.vga_ren = 1'b1; cbi.vga_addr = 24'd6;
      #1;
      chk("arb_evo_blocked", 32'(cbi.evo_rgnt), 32'd0);
      chk("arb_vga_addr", 32'(cbi.ram0_addr), 32'd6);
      tick();
      chk("arb_valids_vga", 32'({cbi.vga_rvalid, cbi.evo_rvalid}), 32'd2);
      cbi.vga_ren = 1'b0;
      #1;
      chk("arb_evo_gnt", 32'(cbi.evo_rgnt), 32'd1);
      chk("arb_evo_addr", 32'(cbi.ram0_addr), 32'd5);
      tick();
      chk("evo_rdata_5", 32'({cbi.evo_rvalid, cbi.evo_rdata, cbi.vga_rvalid}), 32'd6);

      // Generation flip with a same-cycle read and an evolution write
      cbi.evo_raddr = 24'd9; cbi.evo_wen = 1'b1; cbi.evo_waddr = 24'd9; cbi.evo_wdata = 1'b1;
      cbi.gen_done = 1'b1;
      #1;
      chk("evo_wr_bank1", 32'({cbi.ram1_wren, cbi.ram0_wren, cbi.ram1_addr}), {6'd0, 2'b10, 24'd9});
      chk("flip_rd_old", 32'({cbi.ram0_rden, cbi.ram0_addr}), {7'd0, 1'b1, 24'd9});
      tick();
      chk("flip1_bank_cnt", 32'({cbi.cur_bank, cbi.gen_count}), {15'd0, 1'b1, 16'd1});
      chk("flip_rd_data", 32'({cbi.evo_rvalid, cbi.evo_rdata}), 32'd2);
      cbi.gen_done = 1'b0; cbi.evo_rreq = 1'b0; cbi.evo_waddr = 24'd10;
      #1;
      chk("evo_wr_bank0", 32'({cbi.ram0_wren, cbi.ram1_wren, cbi.ram0_addr}), {6'd0, 2'b10, 24'd10});
      tick();
      cbi.evo_wen = 1'b0; cbi.gen_done = 1'b1;
      tick();
      chk("flip2_bank_cnt", 32'({cbi.cur_bank, cbi.gen_count}), {15'd0, 1'b0, 16'd2});
      tick();
      chk("flip3_bank_cnt", 32'({cbi.cur_bank, cbi.gen_count}), {15'd0, 1'b1, 16'd3});
      cbi.gen_done = 1'b0; cbi.evo_rreq = 1'b1; cbi.evo_raddr = 24'd9;
      #1;
      chk("rd_bank1", 32'({cbi.ram1_rden, cbi.ram0_rden, cbi.ram1_addr}), {6'd0, 2'b10, 24'd9});
      tick();
      chk("rd_bank1_data", 32'({cbi.evo_rvalid, cbi.evo_rdata}), 32'd3);
      cbi.evo_rreq = 1'b0;

      // Load from RUN clears the counter, keeps the bank
      cbi.load_req = 1'b1;
      tick();
      chk("load_clr_cnt", 32'({cbi.load_gnt, cbi.cur_bank, cbi.gen_count}), {14'd0, 2'b11, 16'd0});
      cbi.load_req = 1'b0;
      tick();
      tick();

      // Counter wrap
      cbi.gen_done = 1'b1;
      repeat (65535) tick();
      chk("cnt_ffff", 32'({cbi.cur_bank, cbi.gen_count}), {15'd0, 1'b0, 16'hFFFF});
      tick();
      chk("cnt_wrap", 32'({cbi.cur_bank, cbi.gen_count}), {15'd0, 1'b1, 16'd0});
      cbi.gen_done = 1'b0; cbi.evo_en = 1'b0;
      tick();
      cbi.gen_done = 1'b1;
      tick();
      chk("gen_done_idle", 32'({cbi.cur_bank, cbi.gen_count}), {15'd0, 1'b1, 16'd0});
      cbi.gen_done = 1'b0;

      // Cell edits: toggle, toggle back, then VGA-delayed toggle
      edit_cycle(24'd100, 0, n);
      chk("edit1_cycles", 32'(n), 32'd3);
      chk("edit1_busy_clr", 32'(cbi.edit_busy), 32'd0);
      chk("edit1_cells", 32'({mem0[100], mem1[100]}), 32'd3);
      tick();
      chk("edit1_pulse", 32'(cbi.edit_done), 32'd0);
      edit_cycle(24'd100, 0, n);
      chk("edit2_cycles", 32'(n), 32'd3);
      chk("edit2_cells", 32'({mem0[100], mem1[100]}), 32'd0);
      tick();
      edit_cycle(24'd100, 4, n);
      chk("edit3_cycles", 32'(n), 32'd7);
      chk("edit3_cells", 32'({mem0[100], mem1[100]}), 32'd3);
      tick();

      // Reset in the middle of an edit
      cbi.edit_req = 1'b1; cbi.edit_addr = 24'd100;
      tick();
      cbi.edit_req = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_edit", 32'({cbi.edit_busy, cbi.edit_done, cbi.cur_bank, cbi.gen_count}), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_no_done", 32'({cbi.edit_busy, cbi.edit_done}), 32'd0);
      chk("rst_cell_kept", 32'({mem0[100], mem1[100]}), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
